// File: rtl/perceptron_pkg.sv
//------------------------------------------------------------------------------
// perceptron_pkg : state encoding and result-word layout shared by the
//                  perceptron sequencer and its optional performance counters.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package perceptron_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t LOAD    = 3'd1;
  localparam state_t SETTLE  = 3'd2;
  localparam state_t COMPUTE = 3'd3;
  localparam state_t WRITE   = 3'd4;
  localparam state_t DONE    = 3'd5;

  // Wide enough for any BRAM address; users keep the low ADDR_W bits.
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;

  localparam int FIRE_BIT = 16;
  localparam int Y_MSB    = 15;

  function automatic logic [31:0] pack_result(input logic f, input logic [15:0] y);
    pack_result              = '0;
    pack_result[FIRE_BIT]    = f;
    pack_result[Y_MSB:0]     = y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/perceptron_perf_counter.sv
//------------------------------------------------------------------------------
// perceptron_perf_counter : inference and fire counters, built only when
//                           PERCEPTRON_SEQ_PERF_COUNT_EN is defined.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
module perceptron_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_pulse,
  input  logic        result_fire,
  output logic [15:0] inference_count,
  output logic [15:0] fire_count
);

  logic [15:0] r_inference_count;
  logic [15:0] r_fire_count;

  // Both counters wrap naturally at 16'hFFFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inference_count <= '0;
      r_fire_count      <= '0;
    end else if (done_pulse) begin
      r_inference_count <= r_inference_count + 16'd1;
      if (result_fire) begin
        r_fire_count <= r_fire_count + 16'd1;
      end
    end
  end

  assign inference_count = r_inference_count;
  assign fire_count      = r_fire_count;

endmodule
`endif

`default_nettype wire

// File: rtl/perceptron_sequencer.sv
//------------------------------------------------------------------------------
// perceptron_sequencer : loads N {w,x} words into the perceptron controller,
//   holds enable for a compute window, then writes {fire,y} back to BRAM.
//   Optional counters: define PERCEPTRON_SEQ_PERF_COUNT_EN.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module perceptron_sequencer
  import perceptron_pkg::*;
#(
  parameter int N              = 8,
  parameter int ADDR_W         = 9,
  parameter int COMPUTE_CYCLES = 4,
  parameter int OUT_ADDR       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [31:0]       bram_wdata,
  output logic [ADDR_W-1:0] ctrl_data_addr,
  output logic              perceptron_enable,
  input  logic [15:0]       perceptron_out,
  input  logic              fire,
  output logic [15:0]       result,
  output logic              result_fire
`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
  ,
  output logic [15:0]       inference_count,
  output logic [15:0]       fire_count
`endif
);

  localparam int IDX_W = $clog2(N) + 1;
  localparam int CNT_W = $clog2(COMPUTE_CYCLES) + 1;

  localparam logic [ADDR_W-1:0] c_idle_addr = IDLE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] c_out_addr  = ADDR_W'(OUT_ADDR);
  localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0]  c_cnt_load  = CNT_W'(COMPUTE_CYCLES - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_bram_addr;
  logic                r_bram_we;
  logic [31:0]         r_bram_wdata;
  logic [ADDR_W-1:0]   r_ctrl_addr;
  logic                r_enable;
  logic [15:0]         r_result;
  logic                r_result_fire;

  logic [IDX_W-1:0]    w_idx_next;

  assign w_idx_next = r_idx + 1'b1;

  // Every output is registered; each transition sets the values the next
  // state presents, so bram_addr and ctrl_data_addr carry idx in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_bram_addr   <= '0;
      r_bram_we     <= 1'b0;
      r_bram_wdata  <= '0;
      r_ctrl_addr   <= c_idle_addr;
      r_enable      <= 1'b0;
      r_result      <= '0;
      r_result_fire <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_bram_addr <= '0;
            r_ctrl_addr <= '0;
          end
        end
        LOAD: begin
          if (r_idx == c_last_idx) begin
            r_state     <= SETTLE;
            r_ctrl_addr <= c_idle_addr;
          end else begin
            r_idx       <= w_idx_next;
            r_bram_addr <= ADDR_W'(w_idx_next);
            r_ctrl_addr <= ADDR_W'(w_idx_next);
          end
        end
        SETTLE: begin
          r_state  <= COMPUTE;
          r_enable <= 1'b1;
          r_cnt    <= c_cnt_load;
        end
        COMPUTE: begin
          if (r_cnt == '0) begin
            r_state      <= WRITE;
            r_enable     <= 1'b0;
            r_bram_addr  <= c_out_addr;
            r_bram_we    <= 1'b1;
            r_bram_wdata <= pack_result(fire, perceptron_out);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WRITE: begin
          r_state       <= DONE;
          r_bram_we     <= 1'b0;
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
          r_result      <= r_bram_wdata[Y_MSB:0];
          r_result_fire <= r_bram_wdata[FIRE_BIT];
        end
        DONE: begin
          r_state     <= IDLE;
          r_done      <= 1'b0;
          r_bram_addr <= '0;
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_bram_we   <= 1'b0;
          r_enable    <= 1'b0;
          r_ctrl_addr <= c_idle_addr;
        end
      endcase
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign bram_addr         = r_bram_addr;
  assign bram_we           = r_bram_we;
  assign bram_wdata        = r_bram_wdata;
  assign ctrl_data_addr    = r_ctrl_addr;
  assign perceptron_enable = r_enable;
  assign result            = r_result;
  assign result_fire       = r_result_fire;

`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
  perceptron_perf_counter u_perf_counter (
    .clk             (clk),
    .rst             (rst),
    .done_pulse      (r_done),
    .result_fire     (r_result_fire),
    .inference_count (inference_count),
    .fire_count      (fire_count)
  );
`else
  // Counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_perceptron_sequencer.sv
//------------------------------------------------------------------------------
// tb_perceptron_sequencer : randomized self-checking bench with a BRAM and
//   controller-latch model plus a cycle-schedule reference for each run.
//------------------------------------------------------------------------------
`default_nettype none

module tb_perceptron_sequencer;

  localparam int N        = 8;
  localparam int ADDR_W   = 9;
  localparam int CC       = 4;
  localparam int OUT_ADDR = 8;
  localparam int LAT      = N + 1 + CC + 2;
  localparam int RUN_LEN  = LAT + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [31:0]       bram_wdata;
  logic [ADDR_W-1:0] ctrl_data_addr;
  logic              perceptron_enable;
  logic [15:0]       perceptron_out;
  logic              fire;
  logic [15:0]       result;
  logic              result_fire;
`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
  logic [15:0]       inference_count;
  logic [15:0]       fire_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perceptron_sequencer #(
    .N(N), .ADDR_W(ADDR_W), .COMPUTE_CYCLES(CC), .OUT_ADDR(OUT_ADDR)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .bram_addr         (bram_addr),
    .bram_we           (bram_we),
    .bram_wdata        (bram_wdata),
    .ctrl_data_addr    (ctrl_data_addr),
    .perceptron_enable (perceptron_enable),
    .perceptron_out    (perceptron_out),
    .fire              (fire),
    .result            (result),
    .result_fire       (result_fire)
`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
    ,
    .inference_count   (inference_count),
    .fire_count        (fire_count)
`endif
  );

  // Environment: synchronous BRAM and a controller that latches word sel.
  logic [31:0]       mem [0:511];
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] sel = '1;
  logic [15:0]       ctl_x [0:N-1];
  logic [15:0]       ctl_w [0:N-1];
  int                wr_count = 0;
  int                done_count = 0;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  always @(posedge clk) begin
    rdata <= mem[bram_addr];
    sel   <= ctrl_data_addr;
    if (sel < ADDR_W'(N)) begin
      ctl_x[sel[$clog2(N)-1:0]] <= rdata[15:0];
      ctl_w[sel[$clog2(N)-1:0]] <= rdata[31:16];
    end
    if (bram_we) begin
      wr_count <= wr_count + 1;
      wr_addr  <= bram_addr;
      wr_data  <= bram_wdata;
    end
    if (done) done_count <= done_count + 1;
  end

  // Expected output schedule, cycle k counted from the start cycle (k=0).
  typedef struct packed {
    logic              busy;
    logic              done;
    logic              we;
    logic              en;
    logic              addr_valid;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ctrl;
  } exp_t;

  function automatic exp_t model_cycle(input int k);
    exp_t e;
    e      = '0;
    e.ctrl = '1;
    if (k >= 1 && k <= N) begin
      e.busy = 1'b1; e.addr_valid = 1'b1;
      e.addr = ADDR_W'(k - 1); e.ctrl = ADDR_W'(k - 1);
    end else if (k == N + 1) begin
      e.busy = 1'b1;
    end else if (k >= N + 2 && k <= N + 1 + CC) begin
      e.busy = 1'b1; e.en = 1'b1;
    end else if (k == N + 2 + CC) begin
      e.busy = 1'b1; e.we = 1'b1; e.addr_valid = 1'b1; e.addr = ADDR_W'(OUT_ADDR);
    end else if (k == LAT) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  // Per-cycle trace of one run.
  logic              t_busy  [0:RUN_LEN];
  logic              t_done  [0:RUN_LEN];
  logic              t_we    [0:RUN_LEN];
  logic              t_en    [0:RUN_LEN];
  logic [ADDR_W-1:0] t_addr  [0:RUN_LEN];
  logic [ADDR_W-1:0] t_ctrl  [0:RUN_LEN];
  logic [31:0]       t_wdata [0:RUN_LEN];

  task automatic do_run(input logic [63:0] extra_start);
    start = 1'b1;
    for (int k = 1; k <= RUN_LEN; k++) begin
      @(negedge clk);
      t_busy[k] = busy;  t_done[k] = done;  t_we[k] = bram_we;
      t_en[k]   = perceptron_enable;  t_addr[k] = bram_addr;
      t_ctrl[k] = ctrl_data_addr;     t_wdata[k] = bram_wdata;
      start     = extra_start[k];
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; perceptron_out = '0; fire = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bram_we, perceptron_enable} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 0000", {busy, done, bram_we, perceptron_enable});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bram_addr, ctrl_data_addr} !== {9'h000, 9'h1FF}) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h expected 000/1ff", bram_addr, ctrl_data_addr);
    end
    checks++;
    if ({result, result_fire} !== 17'h0) begin
      errors++;
      $display("FAIL reset_result: got %h/%b expected 0000/0", result, result_fire);
    end
`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
    checks++;
    if ({inference_count, fire_count} !== 32'h0) begin
      errors++;
      $display("FAIL reset_perf: got %h/%h expected 0/0", inference_count, fire_count);
    end
`endif
  endtask

  task automatic test_idle;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bram_we, busy, done, ctrl_data_addr} !== {3'b000, 9'h1FF}) begin
        errors++;
        $display("FAIL idle_cycle%0d: got we=%b busy=%b done=%b ctrl=%h expected 0/0/0/1ff",
                 k, bram_we, busy, done, ctrl_data_addr);
      end
    end
    checks++;
    if (wr_count !== 0) begin
      errors++;
      $display("FAIL idle_writes: got %0d expected 0", wr_count);
    end
  endtask

  task automatic test_single_run;
    int   w0;
    exp_t e;
    for (int k = 0; k < N; k++) mem[k] = {16'(k + 1), 16'(k + 16)};
    perceptron_out = 16'h1234; fire = 1'b1;
    w0 = wr_count;
    do_run('0);
    for (int k = 1; k <= RUN_LEN; k++) begin
      e = model_cycle(k);
      checks++;
      if ({t_busy[k], t_done[k], t_we[k], t_en[k], t_ctrl[k]} !== {e.busy, e.done, e.we, e.en, e.ctrl}) begin
        errors++;
        $display("FAIL single_cycle%0d: got b/d/we/en/ctrl=%b%b%b%b/%h expected %b%b%b%b/%h", k,
                 t_busy[k], t_done[k], t_we[k], t_en[k], t_ctrl[k], e.busy, e.done, e.we, e.en, e.ctrl);
      end
      if (e.addr_valid) begin
        checks++;
        if (t_addr[k] !== e.addr) begin
          errors++;
          $display("FAIL single_addr%0d: got %h expected %h", k, t_addr[k], e.addr);
        end
      end
    end
    checks++;
    if (t_wdata[N + 2 + CC] !== 32'h0001_1234) begin
      errors++;
      $display("FAIL single_wdata: got %h expected 00011234", t_wdata[N + 2 + CC]);
    end
    checks++;
    if ({result, result_fire} !== {16'h1234, 1'b1}) begin
      errors++;
      $display("FAIL single_result: got %h/%b expected 1234/1", result, result_fire);
    end
    checks++;
    if (wr_count - w0 !== 1 || wr_addr !== ADDR_W'(OUT_ADDR)) begin
      errors++;
      $display("FAIL single_write: got count=%0d addr=%h expected 1/%h", wr_count - w0, wr_addr, OUT_ADDR);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ctl_x[k] !== 16'(k + 16) || ctl_w[k] !== 16'(k + 1)) begin
        errors++;
        $display("FAIL align%0d: got x=%h w=%h expected x=%h w=%h", k, ctl_x[k], ctl_w[k], 16'(k + 16), 16'(k + 1));
      end
    end
  endtask

  task automatic test_random_runs;
    int   w0;
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) mem[k] = $urandom;
      perceptron_out = 16'($urandom); fire = 1'($urandom_range(0, 1));
      w0 = wr_count;
      do_run('0);
      for (int k = 1; k <= RUN_LEN; k++) begin
        e = model_cycle(k);
        checks++;
        if ({t_busy[k], t_done[k], t_we[k], t_en[k], t_ctrl[k]} !== {e.busy, e.done, e.we, e.en, e.ctrl} ||
            (e.addr_valid && t_addr[k] !== e.addr)) begin
          errors++;
          $display("FAIL rand%0d_cycle%0d: got b/d/we/en/addr/ctrl=%b%b%b%b/%h/%h expected %b%b%b%b/%h/%h",
                   r, k, t_busy[k], t_done[k], t_we[k], t_en[k], t_addr[k], t_ctrl[k],
                   e.busy, e.done, e.we, e.en, e.addr, e.ctrl);
        end
      end
      checks++;
      if (t_wdata[N + 2 + CC] !== {15'b0, fire, perceptron_out} || wr_count - w0 !== 1) begin
        errors++;
        $display("FAIL rand%0d_write: got %h count=%0d expected %h count=1", r,
                 t_wdata[N + 2 + CC], wr_count - w0, {15'b0, fire, perceptron_out});
      end
      checks++;
      if ({result, result_fire} !== {perceptron_out, fire}) begin
        errors++;
        $display("FAIL rand%0d_result: got %h/%b expected %h/%b", r, result, result_fire, perceptron_out, fire);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({ctl_w[k], ctl_x[k]} !== mem[k]) begin
          errors++;
          $display("FAIL rand%0d_align%0d: got %h expected %h", r, k, {ctl_w[k], ctl_x[k]}, mem[k]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy;
    int          d0;
    int          w0;
    logic [63:0] extra;
    extra = '0;
    extra[3] = 1'b1; extra[10] = 1'b1; extra[LAT] = 1'b1; extra[RUN_LEN] = 1'b1;
    perceptron_out = 16'($urandom); fire = 1'($urandom_range(0, 1));
    d0 = done_count; w0 = wr_count;
    do_run(extra);
    for (int k = 1; k <= RUN_LEN; k++) begin
      checks++;
      if ({t_done[k], t_we[k], t_busy[k]} !== {model_cycle(k).done, model_cycle(k).we, model_cycle(k).busy}) begin
        errors++;
        $display("FAIL busy_start_cycle%0d: got d/we/b=%b%b%b expected %b%b%b", k, t_done[k], t_we[k], t_busy[k],
                 model_cycle(k).done, model_cycle(k).we, model_cycle(k).busy);
      end
    end
    checks++;
    if (done_count - d0 !== 1 || wr_count - w0 !== 1) begin
      errors++;
      $display("FAIL busy_start_runs: got done=%0d writes=%0d expected 1/1", done_count - d0, wr_count - w0);
    end
    // start was held through the idle cycle after done: a second run follows.
    do_run('0);
    checks++;
    if (t_done[LAT] !== 1'b1 || t_busy[1] !== 1'b1 || done_count - d0 !== 2 || wr_count - w0 !== 2) begin
      errors++;
      $display("FAIL back_to_back: got done@LAT=%b busy@1=%b runs=%0d writes=%0d expected 1/1/2/2",
               t_done[LAT], t_busy[1], done_count - d0, wr_count - w0);
    end
  endtask

  task automatic test_reset_mid_compute;
    int d0;
    int w0;
    perceptron_out = 16'($urandom); fire = 1'b1;
    d0 = done_count; w0 = wr_count;
    start = 1'b1;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (perceptron_enable !== 1'b1) begin
      errors++;
      $display("FAIL mid_compute_enable: got %b expected 1", perceptron_enable);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({perceptron_enable, busy, bram_we, ctrl_data_addr} !== {3'b000, 9'h1FF}) begin
      errors++;
      $display("FAIL async_reset: got en/busy/we/ctrl=%b%b%b/%h expected 000/1ff",
               perceptron_enable, busy, bram_we, ctrl_data_addr);
    end
`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
    checks++;
    if (inference_count !== 16'd0) begin
      errors++;
      $display("FAIL perf_after_reset: got %0d expected 0", inference_count);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_count !== d0 || wr_count !== w0 || result !== 16'h0) begin
      errors++;
      $display("FAIL reset_no_write: got done=%0d writes=%0d result=%h expected 0/0/0000",
               done_count - d0, wr_count - w0, result);
    end
    do_run('0);
    checks++;
    if (t_done[LAT] !== 1'b1 || wr_count - w0 !== 1 || {result, result_fire} !== {perceptron_out, 1'b1}) begin
      errors++;
      $display("FAIL run_after_reset: got done@LAT=%b writes=%0d result=%h/%b expected 1/1/%h/1",
               t_done[LAT], wr_count - w0, result, result_fire, perceptron_out);
    end
`ifdef PERCEPTRON_SEQ_PERF_COUNT_EN
    checks++;
    if (inference_count !== 16'd1 || fire_count !== 16'd1) begin
      errors++;
      $display("FAIL perf_after_run: got %0d/%0d expected 1/1", inference_count, fire_count);
    end
`endif
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = '0;
    test_reset();
    test_idle();
    test_single_run();
    test_random_runs();
    test_start_while_busy();
    test_reset_mid_compute();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/perceptron_sequencer.md
Name: perceptron_sequencer

Overview:
- Upstream control stage for the perceptron controller.
- On a start pulse it walks BRAM addresses 0..N-1 so the controller latches each {w,x} word into its input registers. It then holds the perceptron enable for a fixed compute window.
- Finally it writes {fire, y} back to the BRAM result address and pulses done.
- Sits between the host/top-level start logic, the dual-purpose BRAM port, and the perceptron controller.

Parameters:
- N, 8, number of inputs; number of BRAM words loaded (addresses 0..N-1).
- ADDR_W, 9, BRAM address width.
- COMPUTE_CYCLES, 4, cycles the perceptron enable is held high; must be >= 1.
- OUT_ADDR, 8, BRAM address receiving the result word; must be >= N.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result write has completed.
- bram_addr  out  ADDR_W  BRAM address; synchronous read, 1-cycle latency.
- bram_we  out  1  BRAM write enable.
- bram_wdata  out  32  write data {15'b0, fire, perceptron_out}.
- ctrl_data_addr  out  ADDR_W  drives the controller's bram_data_addr.
- perceptron_enable  out  1  drives the controller's enable.
- perceptron_out  in  16  controller result y.
- fire  in  1  controller fire flag.
- result  out  16  last captured y.
- result_fire  out  1  last captured fire.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, bram_we=0, perceptron_enable=0.
  - bram_addr=0, ctrl_data_addr={ADDR_W{1'b1}}, result=0, result_fire=0.
- Idle address: ctrl_data_addr={ADDR_W{1'b1}} in every state except LOAD, so the controller decodes no one-hot enable.
- IDLE:
  - start=1 -> LOAD, idx=0.
  - start is ignored in all other states (no queueing).
- LOAD (N cycles, idx=0..N-1): bram_addr=idx and ctrl_data_addr=idx in the same cycle.
  - BRAM returns word idx in cycle t+1.
  - The controller registers the one-hot for idx in t+1 and latches the data at the end of t+1, so the alignment is exact with no extra delay.
  - After idx=N-1 -> SETTLE.
- SETTLE (1 cycle): last word latches in the controller; ctrl_data_addr=idle.
- COMPUTE (COMPUTE_CYCLES cycles): perceptron_enable=1, driven from a down-counter. At expiry -> WRITE.
- WRITE (1 cycle): bram_addr=OUT_ADDR, bram_we=1, bram_wdata={15'b0, fire, perceptron_out}, result/result_fire captured -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
  - start in DONE is ignored; a new start is accepted in IDLE the next cycle.
- busy: 1 in LOAD, SETTLE, COMPUTE and WRITE.
- Outputs: all are registered; none are combinational from inputs.
- Total latency: start accepted -> done high = N + 1 + COMPUTE_CYCLES + 2 cycles; 15 with defaults.
- Reset mid-operation: immediate return to IDLE, no write issued. Partial controller registers are left as-is; the controller shares rst polarity handling at top level.
- idx counter width: $clog2(N)+1, no wrap inside LOAD.

Optional Feature:
- Macro PERCEPTRON_SEQ_PERF_COUNT_EN.
- Defined:
  - Extra output port inference_count (16 bits), reset 0.
  - Increments on each DONE cycle; wraps 16'hFFFF -> 0.
  - Extra output fire_count (16 bits), incremented on DONE when result_fire=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package perceptron_pkg:
  - state enum {IDLE, LOAD, SETTLE, COMPUTE, WRITE, DONE}.
  - IDLE_ADDR constant (all ones).
  - Result word packing constants (FIRE_BIT=16, Y_MSB=15).
- No sub-module required. The optional counters may live in one small sub-module, perceptron_perf_counter, instantiated under the macro.

Test Plan:
- Reset then idle:
  - Hold rst=0 for 3 cycles, release -> all outputs at reset values.
  - ctrl_data_addr=9'h1FF; no bram_we for 20 cycles.
- Single run, N=8, COMPUTE_CYCLES=4:
  - Pulse start -> bram_addr 0..7 on consecutive cycles, ctrl_data_addr equal to it.
  - perceptron_enable high for exactly 4 cycles.
  - bram_we once at addr 8; done exactly 15 cycles after start.
- Data alignment:
  - BRAM model holds word k = {16'(k+1), 16'(k+0x10)}.
  - Controller x/w registers after SETTLE must hold x[k]=k+0x10, w[k]=k+1 for all k.
- Result write:
  - Force perceptron_out=16'h1234, fire=1 during COMPUTE.
  - bram_wdata=32'h0001_1234 in the WRITE cycle; result=16'h1234, result_fire=1 after done.
- Start while busy:
  - Pulse start at cycles 3 and 10 of a run, and again in DONE.
  - Exactly one run occurs; a start on the cycle after done launches a second run.
- Reset mid-COMPUTE:
  - Assert rst in the 2nd COMPUTE cycle -> perceptron_enable drops asynchronously, no write, no done.
  - The next start runs normally.
  - With PERCEPTRON_SEQ_PERF_COUNT_EN defined, inference_count reads 0 after reset and 1 after the run.
